// File: rtl/alu_pkg.sv
// Shared opcode encoding for the alu and its issuer, plus FIFO pointer sizing.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_TWOS = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_ROR  = 3'b111;

  // One extra MSB so full and empty can be told apart without a counter.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/alu_op_issuer_if.sv
// Command, alu-side and result signals of the issuer; slave is the issuer's view.
interface alu_op_issuer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_rout;
  logic             alu_ovf;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;
  logic [2:0]       res_sel;
  logic [CNTW-1:0]  op_count;
  logic [CNTW-1:0]  ovf_count;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, alu_rout, alu_ovf, res_ready,
    output cmd_ready, alu_sel, alu_a, alu_b, res_valid, res_data, res_ovf, res_sel,
    output op_count, ovf_count
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, alu_rout, alu_ovf, res_ready,
    input  cmd_ready, alu_sel, alu_a, alu_b, res_valid, res_data, res_ovf, res_sel,
    input  op_count, ovf_count
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO holding packed {sel, a, b}; push/pop are ignored when full/empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [3+2*WIDTH-1:0] data_i,
  input  logic                 pop_i,
  output logic [3+2*WIDTH-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);
  localparam int unsigned DW = 3 + 2 * WIDTH;
  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          do_push, do_pop;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    // Power-of-two depth makes the natural overflow the modulo-2*DEPTH wrap.
    wptr_d  = wptr_q + PW'(do_push);
    rptr_d  = rptr_q + PW'(do_pop);
    data_o  = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Queues alu commands, issues them through registered operands to an external combinational
// alu, and returns results in order on a stallable valid/ready port with saturating counters.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input logic            clk_i,
  input logic            rst_ni,
  alu_op_issuer_if.slave bus
);
  localparam int unsigned DW = 3 + 2 * WIDTH;
  localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};

  logic [DW-1:0]    fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic             res_load, issue_load, res_accept;

  logic             issue_valid_q, issue_valid_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_ovf_q, res_ovf_d;
  logic [2:0]       res_sel_q, res_sel_d;
  logic [CNTW-1:0]  op_cnt_q, op_cnt_d;
  logic [CNTW-1:0]  ovf_cnt_q, ovf_cnt_d;

  alu_cmd_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (bus.cmd_valid),
    .data_i ({bus.cmd_sel, bus.cmd_a, bus.cmd_b}),
    .pop_i  (issue_load),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    res_accept = res_valid_q & bus.res_ready;
    res_load   = issue_valid_q & (~res_valid_q | bus.res_ready);
    issue_load = ~fifo_empty & (~issue_valid_q | res_load);

    issue_valid_d = issue_valid_q;
    alu_sel_d     = alu_sel_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    if (issue_load) begin
      issue_valid_d = 1'b1;
      alu_sel_d     = fifo_rdata[DW-1 -: 3];
      alu_a_d       = fifo_rdata[2*WIDTH-1 -: WIDTH];
      alu_b_d       = fifo_rdata[WIDTH-1:0];
    end else if (res_load) begin
      issue_valid_d = 1'b0;
    end

    // alu output is sampled against the operands held in the issue register.
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_sel_d   = res_sel_q;
    if (res_load) begin
      res_valid_d = 1'b1;
      res_data_d  = bus.alu_rout;
      res_ovf_d   = bus.alu_ovf;
      res_sel_d   = alu_sel_q;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end

    op_cnt_d  = op_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (res_accept && op_cnt_q != CntMax) begin
      op_cnt_d = op_cnt_q + CNTW'(1);
    end
    if (res_accept && res_ovf_q && ovf_cnt_q != CntMax) begin
      ovf_cnt_d = ovf_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_valid_q <= 1'b0;
      alu_sel_q     <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_ovf_q     <= 1'b0;
      res_sel_q     <= '0;
      op_cnt_q      <= '0;
      ovf_cnt_q     <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      alu_sel_q     <= alu_sel_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_ovf_q     <= res_ovf_d;
      res_sel_q     <= res_sel_d;
      op_cnt_q      <= op_cnt_d;
      ovf_cnt_q     <= ovf_cnt_d;
    end
  end

  assign bus.cmd_ready = ~fifo_full;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_sel   = res_sel_q;
  assign bus.op_count  = op_cnt_q;
  assign bus.ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer with a behavioural 4-bit alu on the issue port.
module tb_alu_op_issuer;
  import alu_pkg::*;

  typedef struct {
    logic [3:0] d;
    logic       o;
    logic [2:0] s;
  } exp_t;

  typedef struct {
    logic [2:0] s;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  alu_op_issuer_if #(.WIDTH(4), .CNTW(8)) bus ();

  alu_op_issuer #(
    .WIDTH(4),
    .DEPTH(4),
    .CNTW (8)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Carry/borrow flag for ADD/SUB, signed overflow for TWOS, zero otherwise.
  always_comb begin
    bus.alu_rout = 4'h0;
    bus.alu_ovf  = 1'b0;
    case (bus.alu_sel)
      OP_ADD:  {bus.alu_ovf, bus.alu_rout} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OP_SUB:  begin
        bus.alu_rout = bus.alu_a - bus.alu_b;
        bus.alu_ovf  = (bus.alu_a < bus.alu_b);
      end
      OP_TWOS: begin
        bus.alu_rout = ~bus.alu_a + 4'h1;
        bus.alu_ovf  = (bus.alu_a == 4'h8);
      end
      OP_AND:  bus.alu_rout = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_rout = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_rout = bus.alu_a ^ bus.alu_b;
      OP_ROL:  bus.alu_rout = {bus.alu_a[2:0], bus.alu_a[3]};
      OP_ROR:  bus.alu_rout = {bus.alu_a[0], bus.alu_a[3:1]};
      default: bus.alu_rout = 4'h0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", 32'(bus.res_data), 32'(e.d));
        chk("res_ovf", 32'(bus.res_ovf), 32'(e.o));
        chk("res_sel", 32'(bus.res_sel), 32'(e.s));
      end
    end
  end

  task automatic send(input vec_t v, input bit must_ready);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = v.s;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    if (must_ready) chk("cmd_ready_held", 32'(bus.cmd_ready), 32'd1);
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.cmd_ready) begin
      fail_now("send_timeout");
      bus.cmd_valid = 1'b0;
    end else begin
      e.d = v.d;
      e.o = v.o;
      e.s = v.s;
      sb.push_back(e);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic set_res_ready(input logic r);
    @(posedge clk);
    #1 bus.res_ready = r;
  endtask

  vec_t stream_v[8] = '{
    '{OP_SUB,  4'h5, 4'h3, 4'h2, 1'b0},
    '{OP_SUB,  4'h3, 4'h5, 4'hE, 1'b1},
    '{OP_TWOS, 4'h3, 4'h0, 4'hD, 1'b0},
    '{OP_AND,  4'hC, 4'hA, 4'h8, 1'b0},
    '{OP_OR,   4'hC, 4'h3, 4'hF, 1'b0},
    '{OP_XOR,  4'hF, 4'h5, 4'hA, 1'b0},
    '{OP_ROL,  4'h9, 4'h0, 4'h3, 1'b0},
    '{OP_ROR,  4'h9, 4'h0, 4'hC, 1'b0}
  };

  vec_t fill_v[6] = '{
    '{OP_ADD,  4'h1, 4'h1, 4'h2, 1'b0},
    '{OP_ADD,  4'h2, 4'h2, 4'h4, 1'b0},
    '{OP_TWOS, 4'h8, 4'h0, 4'h8, 1'b1},
    '{OP_XOR,  4'h3, 4'h6, 4'h5, 1'b0},
    '{OP_ROL,  4'h8, 4'h0, 4'h1, 1'b0},
    '{OP_ROR,  4'h1, 4'h0, 4'h8, 1'b0}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int accepted;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 3'h0;
    bus.cmd_a     = 4'h0;
    bus.cmd_b     = 4'h0;
    bus.res_ready = 1'b1;

    // Reset values.
    #12;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_res_sel", 32'(bus.res_sel), 32'd0);
    chk("rst_op_count", 32'(bus.op_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single ADD: Res_valid appears only after the second edge following the push.
    fork
      send('{OP_ADD, 4'h3, 4'h4, 4'h7, 1'b0}, 1'b1);
      begin
        @(negedge clk);
        @(posedge clk);
        @(negedge clk) chk("lat_edge1", 32'(bus.res_valid), 32'd0);
        @(negedge clk) chk("lat_edge2_pre", 32'(bus.res_valid), 32'd0);
        @(negedge clk) chk("lat_edge2", 32'(bus.res_valid), 32'd1);
      end
    join
    @(negedge clk);
    chk("op_count_1", 32'(bus.op_count), 32'd1);
    chk("ovf_count_0", 32'(bus.ovf_count), 32'd0);

    // Carry out of ADD.
    send('{OP_ADD, 4'hF, 4'h1, 4'h0, 1'b1}, 1'b1);
    repeat (4) @(negedge clk);
    chk("op_count_2", 32'(bus.op_count), 32'd2);
    chk("ovf_count_1", 32'(bus.ovf_count), 32'd1);

    // Back-to-back stream: one result every cycle.
    fork
      for (int i = 0; i < 8; i++) send(stream_v[i], 1'b1);
      begin
        @(negedge clk);
        @(posedge clk);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          @(negedge clk) chk("stream_rate", 32'(bus.res_valid), 32'd1);
        end
      end
    join
    repeat (3) @(negedge clk);
    chk("op_count_10", 32'(bus.op_count), 32'd10);
    chk("ovf_count_2", 32'(bus.ovf_count), 32'd2);

    // Backpressure: FIFO plus issue and result registers hold DEPTH+2 commands.
    set_res_ready(1'b0);
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!bus.cmd_ready) break;
      if (accepted < 6) begin
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_sel   = fill_v[accepted].s;
        bus.cmd_a     = fill_v[accepted].a;
        bus.cmd_b     = fill_v[accepted].b;
        e.d = fill_v[accepted].d;
        e.o = fill_v[accepted].o;
        e.s = fill_v[accepted].s;
        sb.push_back(e);
      end else begin
        // Past the expected capacity; an unlisted command goes in and trips the count check.
        bus.cmd_valid = 1'b1;
        bus.cmd_sel   = OP_AND;
        bus.cmd_a     = 4'h0;
        bus.cmd_b     = 4'h0;
      end
      accepted++;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
    end
    chk("fill_accepted", 32'(accepted), 32'd6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_res_valid", 32'(bus.res_valid), 32'd1);
      chk("stall_res_data", 32'(bus.res_data), 32'h2);
      chk("stall_res_sel", 32'(bus.res_sel), 32'(OP_ADD));
      chk("stall_alu_a", 32'(bus.alu_a), 32'h2);
      chk("stall_alu_b", 32'(bus.alu_b), 32'h2);
      chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    set_res_ready(1'b1);
    repeat (10) @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("op_count_16", 32'(bus.op_count), 32'd16);
    chk("ovf_count_3", 32'(bus.ovf_count), 32'd3);

    // Asynchronous reset with three commands in flight.
    send('{OP_ADD, 4'h7, 4'h7, 4'hE, 1'b0}, 1'b0);
    send('{OP_OR,  4'h1, 4'h2, 4'h3, 1'b0}, 1'b0);
    send('{OP_AND, 4'h6, 4'h3, 4'h2, 1'b0}, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("arst_op_count", 32'(bus.op_count), 32'd0);
    chk("arst_alu_sel", 32'(bus.alu_sel), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("post_rst_op_count", 32'(bus.op_count), 32'd0);
    chk("post_rst_ovf_count", 32'(bus.ovf_count), 32'd0);

    // Saturation: 260 overflowing results.
    for (int i = 0; i < 254; i++) send('{OP_ADD, 4'hF, 4'h1, 4'h0, 1'b1}, 1'b1);
    repeat (4) @(negedge clk);
    chk("op_count_fe", 32'(bus.op_count), 32'hFE);
    chk("ovf_count_fe", 32'(bus.ovf_count), 32'hFE);
    for (int i = 0; i < 6; i++) send('{OP_ADD, 4'hF, 4'h1, 4'h0, 1'b1}, 1'b1);
    repeat (4) @(negedge clk);
    chk("op_count_sat", 32'(bus.op_count), 32'hFF);
    chk("ovf_count_sat", 32'(bus.ovf_count), 32'hFF);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
